// File: rtl/gate_reduce_pkg.sv
// Shared definitions for the gate-reduce accumulator.
//   - Op encodings for the per-beat reduction select.
//   - FSM state type for the frame controller.
//   - Helpers giving the per-op identity value and accumulate step.
package gate_reduce_pkg;

  localparam logic [1:0] OpAnd  = 2'd0;
  localparam logic [1:0] OpOr   = 2'd1;
  localparam logic [1:0] OpXor  = 2'd2;
  localparam logic [1:0] OpNand = 2'd3;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAcc  = 2'd1,
    StHold = 2'd2
  } state_e;

  // Starting accumulator value: 1 for AND/NAND, 0 for OR/XOR.
  function automatic logic op_identity(input logic [1:0] op);
    return (op == OpOr || op == OpXor) ? 1'b0 : 1'b1;
  endfunction

  // Fold one reduced beat into the running accumulator.
  // NAND accumulates as AND; the inversion is applied on the way out.
  function automatic logic op_combine(input logic [1:0] op, input logic acc, input logic red);
    logic res;
    unique case (op)
      OpOr:    res = acc | red;
      OpXor:   res = acc ^ red;
      default: res = acc & red;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/gate_reduce_comb.sv
// Per-beat combinational reducer.
//   op   : reduction select (AND, OR, XOR, NAND)
//   data : beat operand bits
//   red  : single-bit reduction of data; NAND reduces as AND (no inversion here)
module gate_reduce_comb
  import gate_reduce_pkg::*;
#(
  parameter int unsigned WIDTH = 5
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data,
  output logic             red
);

  always_comb begin
    red = 1'b0;
    unique case (op)
      OpAnd:   red = &data;
      OpOr:    red = |data;
      OpXor:   red = ^data;
      OpNand:  red = &data;
      default: red = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_reduce_acc.sv
// Frame-level gate reduction accumulator.
// Accepts a frame of beats over a valid/ready input, reduces each beat with the
// op latched on the first beat, folds the results together, and presents one
// result per frame over a valid/ready output along with a saturating beat count.
//   clk, rst           : clock, asynchronous active-high reset
//   op                 : reduction select, sampled on the first beat of a frame
//   in_valid/in_ready  : input beat handshake
//   in_data, in_last   : beat operand and end-of-frame marker
//   out_valid/out_ready: result handshake
//   out_data           : reduced frame result
//   out_beats, out_ovf : accepted beat count (saturating) and saturation flag
module gate_reduce_acc
  import gate_reduce_pkg::*;
#(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_data,
  output logic [CNT_W-1:0] out_beats,
  output logic             out_ovf
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic             acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic             beat_fire;
  logic             first_beat;
  logic [1:0]       op_sel;
  logic             acc_base;
  logic [CNT_W-1:0] cnt_base;
  logic             ovf_base;
  logic             beat_red;

  // A frame starts on any beat accepted in IDLE; that beat seeds op, accumulator
  // and counters instead of continuing from the stored values.
  assign first_beat = (state_q == StIdle);
  assign op_sel     = first_beat ? op : op_q;
  assign acc_base   = first_beat ? op_identity(op) : acc_q;
  assign cnt_base   = first_beat ? '0 : cnt_q;
  assign ovf_base   = first_beat ? 1'b0 : ovf_q;

  gate_reduce_comb #(
    .WIDTH(WIDTH)
  ) u_reduce (
    .op  (op_sel),
    .data(in_data),
    .red (beat_red)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    in_ready  = (state_q != StHold);
    beat_fire = in_valid && in_ready;

    unique case (state_q)
      StIdle, StAcc: begin
        if (beat_fire) begin
          op_d  = op_sel;
          acc_d = op_combine(op_sel, acc_base, beat_red);
          if (cnt_base == CntMax) begin
            cnt_d = cnt_base;
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_base + CntOne;
            ovf_d = ovf_base;
          end
          state_d = in_last ? StHold : StAcc;
        end
      end
      StHold: begin
        // in_ready is low here, so nothing is accepted in the handshake cycle.
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= OpAnd;
      acc_q   <= 1'b1;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Result fields read as zero outside HOLD so reset and idle show a clean bus.
  always_comb begin
    out_valid = (state_q == StHold);
    out_data  = out_valid & (acc_q ^ (op_q == OpNand));
    out_beats = out_valid ? cnt_q : '0;
    out_ovf   = out_valid & ovf_q;
  end

endmodule

// File: doc/gate_reduce_acc.md
GATE_REDUCE_ACC -- requirements
Module: gate_reduce_acc

Interface
REQ-001 SHALL have parameter WIDTH, default 5: bits per input beat, legal range >= 2.
REQ-002 SHALL have parameter CNT_W, default 8: width of the beat counter, legal range >= 2.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port op  input  2  reduction select: 0 AND, 1 OR, 2 XOR, 3 NAND; sampled on the first beat of a frame.
REQ-006 SHALL have port in_valid  input  1  input beat present.
REQ-007 SHALL have port in_ready  output  1  block accepts a beat.
REQ-008 SHALL have port in_data  input  WIDTH  beat operand bits.
REQ-009 SHALL have port in_last  input  1  final beat of the frame.
REQ-010 SHALL have port out_valid  output  1  frame result present.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-012 SHALL have port out_data  output  1  reduced frame result.
REQ-013 SHALL have port out_beats  output  CNT_W  accepted beats in the frame, saturating.
REQ-014 SHALL have port out_ovf  output  1  beat count saturated during the frame.

Function
REQ-015 SHALL transfer a beat only when in_valid and in_ready are both 1 at a rising clk edge.
REQ-016 SHALL reduce each beat over all WIDTH bits: AND/NAND use bitwise AND, OR uses OR, XOR uses XOR.
REQ-017 SHALL accumulate across the beats of a frame from the identity value: 1 for AND/NAND, 0 for OR/XOR.
REQ-018 SHALL latch op on the first beat of a frame; op changes mid-frame SHALL be ignored.
REQ-019 SHALL implement the FSM states IDLE, ACC and HOLD:
- IDLE -> ACC on a non-last beat.
- IDLE -> HOLD on a last beat.
- ACC -> HOLD on a last beat.
- HOLD -> IDLE when out_valid and out_ready are both 1.
REQ-020 SHALL drive in_ready = 1 in IDLE and ACC, and 0 in HOLD.
REQ-021 SHALL assert out_valid only in HOLD, starting the cycle after the last beat is accepted (latency 1 clk).
REQ-022 SHALL drive out_data as the accumulated value, inverted when the latched op is NAND.
REQ-023 SHALL hold out_data, out_beats and out_ovf stable while out_valid=1 and out_ready=0.
REQ-024 SHALL count accepted beats including the last; a single-beat frame SHALL give out_beats=1.
REQ-025 SHALL saturate the count at 2^CNT_W-1; any beat accepted at saturation SHALL set out_ovf, which clears at the next frame start.
REQ-026 SHALL ignore in_data and in_last whenever in_valid=0.
REQ-027 SHALL NOT accept a new beat in the cycle of the output handshake; acceptance resumes in the following cycle.

Reset
REQ-028 SHALL force the following values immediately on rst=1, independent of clk: state IDLE, accumulator at the AND identity, count 0, out_valid 0, out_data 0, out_beats 0, out_ovf 0, in_ready 1 once rst is released.
REQ-029 SHALL discard any partial frame or held result when rst is asserted; no result SHALL be emitted for it.

Structure
REQ-030 SHALL place the op encoding constants and the FSM state typedef in shared package gate_reduce_pkg.
REQ-031 SHALL implement the per-beat combinational reducer as sub-module gate_reduce_comb (parameter WIDTH; inputs op and data; 1-bit output).

Verification
REQ-032 SHALL check, with WIDTH=5, op=AND, a single beat 11111 with last -> out_data=1, out_beats=1, out_ovf=0; a single beat 10101 -> out_data=0.
REQ-033 SHALL check, with op=AND, beats 11111, 11111, 11011 (last) -> out_data=0, out_beats=3.
REQ-034 SHALL check, with op=XOR, beats 00101, 00001 (last) -> out_data=1, out_beats=2; op=NAND on the same beats -> out_data=1.
REQ-035 SHALL check, with CNT_W=2, five beats of op=OR data 00000 -> out_data=0, out_beats=3, out_ovf=1.
REQ-036 SHALL check backpressure: out_ready held 0 for 3 cycles after out_valid -> outputs stable and in_ready=0, then handshake -> IDLE and in_ready=1 one cycle later.
REQ-037 SHALL check reset mid-frame: rst pulsed after 2 beats -> out_valid=0 and no stale result; the next frame starts from the identity value.
